// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a programmable wait-state FSM.
// Define DMEM_BYTE_WRITE_EN to add the byte-enable input be[3:0] for stores.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        Stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                ready_q;
  logic                err_q;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]          be_q;
  logic [3:0]          acc_be;
`endif

  logic [31:0]         mem_q [0:(1 << ADDR_W) - 1];

  logic                acc_we;
  logic [ADDR_W+1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [ADDR_W-1:0]   acc_idx;
  logic                acc_mis;
  logic                commit;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // With no wait states the access completes on its capture edge, so the
  // live inputs stand in for the not-yet-latched copies.
  always_comb begin
    acc_we    = (state_q == IDLE) ? we                : we_q;
    acc_addr  = (state_q == IDLE) ? addr[ADDR_W+1:0]  : addr_q;
    acc_wdata = (state_q == IDLE) ? wdata             : wdata_q;
`ifdef DMEM_BYTE_WRITE_EN
    acc_be    = (state_q == IDLE) ? be                : be_q;
`endif
    acc_idx   = acc_addr[ADDR_W+1:2];
    acc_mis   = (acc_addr[1:0] != 2'b00);
    commit    = ((state_q == IDLE) && req && NO_WAIT) ||
                ((state_q == WAIT) && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_mis && !reset) begin
`ifdef DMEM_BYTE_WRITE_EN
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
`else
      mem_q[acc_idx] <= acc_wdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DMEM_BYTE_WRITE_EN
      be_q    <= '0;
`endif
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
`ifdef DMEM_BYTE_WRITE_EN
            be_q    <= be;
`endif
            cnt_q   <= CNT_INIT;
            state_q <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      ready_q <= commit;
      err_q   <= commit && acc_mis;
      // Memory read sees pre-edge contents; stores leave rdata alone unless misaligned.
      if (commit && (acc_mis || !acc_we)) rdata_q <= acc_mis ? '0 : mem_q[acc_idx];
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign Stall = req & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (ADDR_W=8, WAIT_CYCLES=2).
// Byte-enable cases are built only when DMEM_BYTE_WRITE_EN is defined.
module tb_dmem_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned WC = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        Stall;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  exp_t        sb[$];
  logic [31:0] model_mem [0:255];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be    (be),
`endif
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .Stall (Stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference model: computes the response and updates memory/rdata expectations.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    exp_t        e;
    exp_t        got;
    int unsigned cyc;
    logic        seen;
    logic [7:0]  idx;
    logic        mis;
    idx = a[9:2];
    mis = (a[1:0] != 2'b00);
    if (mis) begin
      model_rdata = '0;
    end else if (!w) begin
      model_rdata = model_mem[idx];
    end else begin
      for (int i = 0; i < 4; i++)
        if (b[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
    end
    e.err   = mis;
    e.rdata = model_rdata;
    sb.push_back(e);

    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef DMEM_BYTE_WRITE_EN
    be = b;
`endif
    #1 chk("stall_cycle0", {31'd0, Stall}, 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        we = ~w; addr = a ^ 32'h0000_0044; wdata = ~d;
`ifdef DMEM_BYTE_WRITE_EN
        be = ~b;
`endif
      end
      #1;
      if (ready === 1'b1) seen = 1'b1;
      else chk("stall_wait", {31'd0, Stall}, 32'd1);
    end
    chk("latency", cyc, WC + 1);
    chk("stall_resp", {31'd0, Stall}, 32'd0);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("err", {31'd0, err}, {31'd0, got.err});
      chk("rdata", rdata, got.rdata);
    end
    req = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_pulse", {31'd0, ready}, 32'd0);
    chk("err_idle", {31'd0, err}, 32'd0);
    chk("rdata_hold", rdata, model_rdata);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef DMEM_BYTE_WRITE_EN
    be = 4'h0;
`endif
    model_rdata = '0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_ready", {31'd0, ready}, 32'd0);
      chk("idle_stall", {31'd0, Stall}, 32'd0);
    end

    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    access(1'b0, 32'h0000_0010, 32'h0,         4'hF);
    access(1'b1, 32'h0000_0014, 32'h0BAD_F00D, 4'hF);
    access(1'b0, 32'h0000_0013, 32'h0,         4'hF);
    access(1'b0, 32'h0000_0010, 32'h0,         4'hF);
    access(1'b1, 32'h0000_0410, 32'h1234_5678, 4'hF);
    access(1'b0, 32'h0000_0010, 32'h0,         4'hF);
    access(1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF);
    access(1'b0, 32'h0000_0010, 32'h0,         4'hF);

    // Store to 0x20 that is abandoned by reset one cycle after capture.
    access(1'b1, 32'h0000_0020, 32'h0102_0304, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'hAAAA_5555;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("abort_no_ready", {31'd0, ready}, 32'd0);
    end
    req = 1'b0;
    reset = 1'b0;
    model_rdata = '0;
    access(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    access(1'b0, 32'h0000_0014, 32'h0, 4'hF);

`ifdef DMEM_BYTE_WRITE_EN
    access(1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF);
    access(1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0010);
    access(1'b0, 32'h0000_0030, 32'h0,         4'hF);
    access(1'b1, 32'h0000_0030, 32'h0000_0000, 4'b0000);
    access(1'b0, 32'h0000_0030, 32'h0,         4'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
